log2_seq_ctrl: RTL and testbench

//  Sequencing controller and iterative datapath for fixed-point log base 2 of an unsigned word.

---
 rtl/log2_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_log2_seq_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/log2_seq_ctrl.sv
// Fixed-point log2 of an unsigned word: bit-serial normalise, then FRAC_W squaring steps.
// Latency: clz+1+FRAC_W edges after the accept edge for a nonzero operand; a zero operand completes on the accept edge.
// Backpressure: one operation in flight; the result is held in DONE until res_ready_i, and req_ready_o stays low until then.
//
// Ports:
//   clk_i, rst_i (async, active-high), clear_i (sync abort to IDLE)
//   req_valid_i / req_ready_o / data_i                    operand handshake
//   res_valid_o / res_ready_i / res_int_o / res_frac_o    result handshake
//   err_o (zero operand, qualified by res_valid_o), busy_o (NORM or FRAC)
module log2_seq_ctrl #(
    parameter int DATA_W = 32,
    parameter int MW     = 16,
    parameter int FRAC_W = 8,
    localparam int INT_W = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [DATA_W-1:0] data_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [INT_W-1:0]  res_int_o,
    output logic [FRAC_W-1:0] res_frac_o,
    output logic              err_o,
    output logic              busy_o
);

    localparam int IT_W = $clog2(FRAC_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_NORM,
        S_FRAC,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   x_q, x_d;
    logic [INT_W-1:0]    cnt_q, cnt_d;
    logic [MW-1:0]       m_q, m_d;
    logic [IT_W-1:0]     iter_q, iter_d;
    logic [INT_W-1:0]    res_int_q, res_int_d;
    logic [FRAC_W-1:0]   res_frac_q, res_frac_d;
    logic                err_q, err_d;

    // Square of the Q1.(MW-1) mantissa is Q2.(2MW-2); it never overflows since m < 2.
    logic [2*MW-1:0]     prod;
    logic                frac_bit;
    logic [MW-1:0]       m_sq_norm;
    logic                unused_prod;

    assign prod      = {{MW{1'b0}}, m_q} * {{MW{1'b0}}, m_q};
    // A square >= 2 yields a 1 bit and is halved back into [1,2); otherwise it is already in range.
    assign frac_bit  = prod[2*MW-1];
    assign m_sq_norm = frac_bit ? prod[2*MW-1 -: MW] : prod[2*MW-2 -: MW];
    // Low product bits fall below the mantissa precision and are truncated away.
    assign unused_prod = ^prod[MW-2:0];

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        cnt_d      = cnt_q;
        m_d        = m_q;
        iter_d     = iter_q;
        res_int_d  = res_int_q;
        res_frac_d = res_frac_q;
        err_d      = err_q;

        if (clear_i) begin
            // Abort wins over any handshake; result fields are left as they are.
            state_d = S_IDLE;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        if (data_i == '0) begin
                            state_d    = S_DONE;
                            err_d      = 1'b1;
                            res_int_d  = '0;
                            res_frac_d = '0;
                        end else begin
                            state_d = S_NORM;
                            err_d   = 1'b0;
                            x_d     = data_i;
                            cnt_d   = '0;
                        end
                    end
                end
                S_NORM: begin
                    if (x_q[DATA_W-1]) begin
                        state_d   = S_FRAC;
                        m_d       = x_q[DATA_W-1 -: MW];
                        res_int_d = INT_W'(DATA_W - 1) - cnt_q;
                        iter_d    = '0;
                    end else begin
                        x_d   = x_q << 1;
                        cnt_d = cnt_q + INT_W'(1);
                    end
                end
                S_FRAC: begin
                    m_d        = m_sq_norm;
                    res_frac_d = (res_frac_q << 1) | FRAC_W'(frac_bit);
                    if (iter_q == IT_W'(FRAC_W - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        iter_d = iter_q + IT_W'(1);
                    end
                end
                S_DONE: begin
                    if (res_ready_i) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            cnt_q      <= '0;
            m_q        <= '0;
            iter_q     <= '0;
            res_int_q  <= '0;
            res_frac_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            cnt_q      <= cnt_d;
            m_q        <= m_d;
            iter_q     <= iter_d;
            res_int_q  <= res_int_d;
            res_frac_q <= res_frac_d;
            err_q      <= err_d;
        end
    end

    // A pending clear suppresses acceptance in IDLE.
    assign req_ready_o = (state_q == S_IDLE) && !clear_i;
    assign res_valid_o = (state_q == S_DONE);
    assign busy_o      = (state_q == S_NORM) || (state_q == S_FRAC);
    assign res_int_o   = res_int_q;
    assign res_frac_o  = res_frac_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_log2_seq_ctrl.sv
module tb_log2_seq_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        clear_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] data_i = '0;
    logic        res_valid_o;
    logic        res_ready_i = 1'b0;
    logic [4:0]  res_int_o;
    logic [7:0]  res_frac_o;
    logic        err_o;
    logic        busy_o;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [4:0] int_v;
        logic [7:0] frac;
        logic       err;
        int         lat;
    } exp_t;

    typedef struct {
        logic [4:0] int_v;
        logic [7:0] frac;
        logic       err;
        int         lat;
        int         busy_gap;
        logic       stable;
        logic       idle_after;
        logic       timeout;
    } obs_t;

    exp_t sb_q[$];

    log2_seq_ctrl dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (clear_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .data_i      (data_i),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_int_o   (res_int_o),
        .res_frac_o  (res_frac_o),
        .err_o       (err_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference: MSB search, normalise, then 8 truncating squarings. Latency is
    // counted in edges after the accept edge (a zero operand is DONE on that edge).
    function automatic exp_t model(input logic [31:0] d);
        exp_t        e;
        logic [31:0] x;
        logic [15:0] m;
        logic [31:0] p;
        int          msb;
        e = '{int_v: '0, frac: '0, err: 1'b0, lat: 0};
        if (d == 32'h0) begin
            e.err = 1'b1;
            return e;
        end
        msb = 0;
        for (int i = 0; i < 32; i++) if (d[i]) msb = i;
        e.int_v = 5'(msb);
        x = d << (31 - msb);
        m = x[31:16];
        for (int k = 0; k < 8; k++) begin
            p = {16'h0, m} * {16'h0, m};
            if (p[31]) begin
                e.frac = {e.frac[6:0], 1'b1};
                m = p[31:16];
            end else begin
                e.frac = {e.frac[6:0], 1'b0};
                m = p[30:15];
            end
        end
        e.lat = (31 - msb) + 1 + 8;
        return e;
    endfunction

    // Drives one operand, pushes its expectation, and observes the result.
    task automatic run_op(input logic [31:0] d, input int hold, output obs_t o);
        int guard;
        o = '{int_v: '0, frac: '0, err: 1'b0, lat: 0, busy_gap: 0,
              stable: 1'b1, idle_after: 1'b0, timeout: 1'b0};
        @(negedge clk_i);
        guard = 0;
        while (!req_ready_o && guard < 200) begin
            @(negedge clk_i);
            guard++;
        end
        if (!req_ready_o) o.timeout = 1'b1;
        req_valid_i = 1'b1;
        data_i      = d;
        sb_q.push_back(model(d));
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        guard = 0;
        while (!res_valid_o && guard < 200) begin
            if (!busy_o) o.busy_gap++;
            @(negedge clk_i);
            o.lat++;
            guard++;
        end
        if (!res_valid_o) o.timeout = 1'b1;
        o.int_v = res_int_o;
        o.frac  = res_frac_o;
        o.err   = err_o;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk_i);
            if (res_int_o !== o.int_v || res_frac_o !== o.frac || err_o !== o.err ||
                res_valid_o !== 1'b1 || req_ready_o !== 1'b0)
                o.stable = 1'b0;
        end
        res_ready_i = 1'b1;
        @(negedge clk_i);
        res_ready_i = 1'b0;
        o.idle_after = !res_valid_o && req_ready_o && !busy_o;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready_o); end
        n_cmp++; if (res_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b want 0", res_valid_o); end
        n_cmp++; if (res_int_o !== 5'd0) begin n_fail++; $display("FAIL reset_int: got %0d want 0", res_int_o); end
        n_cmp++; if (res_frac_o !== 8'h00) begin n_fail++; $display("FAIL reset_frac: got %h want 00", res_frac_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_msb_set();
        obs_t o;
        exp_t e;
        run_op(32'h8000_0000, 0, o);
        e = sb_q.pop_front();
        n_cmp++; if (o.timeout) begin n_fail++; $display("FAIL msb_timeout: got timeout want result"); end
        n_cmp++; if (o.int_v !== 5'd31 || o.int_v !== e.int_v) begin n_fail++; $display("FAIL msb_int: got %0d want 31", o.int_v); end
        n_cmp++; if (o.frac !== 8'h00 || o.frac !== e.frac) begin n_fail++; $display("FAIL msb_frac: got %h want 00", o.frac); end
        n_cmp++; if (o.err !== 1'b0) begin n_fail++; $display("FAIL msb_err: got %b want 0", o.err); end
        n_cmp++; if (o.lat != 9) begin n_fail++; $display("FAIL msb_latency: got %0d want 9", o.lat); end
    endtask

    task automatic test_min_one();
        obs_t o;
        exp_t e;
        run_op(32'h0000_0001, 0, o);
        e = sb_q.pop_front();
        n_cmp++; if (o.int_v !== 5'd0 || o.frac !== 8'h00) begin n_fail++; $display("FAIL one_result: got %0d.%h want 0.00", o.int_v, o.frac); end
        n_cmp++; if (o.lat != 40 || o.lat != e.lat) begin n_fail++; $display("FAIL one_latency: got %0d want 40", o.lat); end
        n_cmp++; if (o.busy_gap != 0) begin n_fail++; $display("FAIL one_busy: got %0d idle cycles want 0", o.busy_gap); end
    endtask

    task automatic test_fraction();
        obs_t o;
        exp_t e;
        run_op(32'd3, 0, o);
        e = sb_q.pop_front();
        n_cmp++; if (o.int_v !== 5'd1 || o.frac !== 8'h95 || o.frac !== e.frac) begin n_fail++; $display("FAIL frac_3: got %0d.%h want 1.95", o.int_v, o.frac); end
        run_op(32'd10, 0, o);
        e = sb_q.pop_front();
        n_cmp++; if (o.int_v !== 5'd3 || o.frac !== 8'h52 || o.frac !== e.frac) begin n_fail++; $display("FAIL frac_10: got %0d.%h want 3.52", o.int_v, o.frac); end
        n_cmp++; if (o.lat != e.lat) begin n_fail++; $display("FAIL frac_10_latency: got %0d want %0d", o.lat, e.lat); end
    endtask

    task automatic test_zero();
        obs_t o;
        exp_t e;
        run_op(32'h0, 0, o);
        e = sb_q.pop_front();
        n_cmp++; if (o.err !== 1'b1) begin n_fail++; $display("FAIL zero_err: got %b want 1", o.err); end
        n_cmp++; if (o.int_v !== 5'd0 || o.frac !== 8'h00) begin n_fail++; $display("FAIL zero_fields: got %0d.%h want 0.00", o.int_v, o.frac); end
        n_cmp++; if (o.lat != e.lat) begin n_fail++; $display("FAIL zero_latency: got %0d want %0d", o.lat, e.lat); end
    endtask

    task automatic test_backpressure();
        obs_t o;
        exp_t e;
        run_op(32'h1234_5678, 5, o);
        e = sb_q.pop_front();
        n_cmp++; if (o.int_v !== e.int_v || o.frac !== e.frac) begin n_fail++; $display("FAIL bp_result: got %0d.%h want %0d.%h", o.int_v, o.frac, e.int_v, e.frac); end
        n_cmp++; if (o.stable !== 1'b1) begin n_fail++; $display("FAIL bp_stable: got unstable want stable"); end
        n_cmp++; if (o.idle_after !== 1'b1) begin n_fail++; $display("FAIL bp_release: got not idle want idle"); end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        exp_t e;
        logic [31:0] d;
        for (int i = 0; i < 8; i++) begin
            d = $urandom() >> $urandom_range(31, 0);
            run_op(d, 0, o);
            e = sb_q.pop_front();
            n_cmp++;
            if (o.timeout || o.int_v !== e.int_v || o.frac !== e.frac || o.err !== e.err || o.lat != e.lat || !o.idle_after) begin
                n_fail++;
                $display("FAIL b2b_%0d d=%h: got %0d.%h err=%b lat=%0d want %0d.%h err=%b lat=%0d",
                         i, d, o.int_v, o.frac, o.err, o.lat, e.int_v, e.frac, e.err, e.lat);
            end
        end
    endtask

    task automatic test_clear();
        obs_t o;
        exp_t e;
        logic seen;
        @(negedge clk_i);
        req_valid_i = 1'b1;
        data_i      = 32'h0000_00FF;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        clear_i = 1'b1;
        // Also offer an operand while clear is held in IDLE: it must not be taken.
        @(negedge clk_i);
        n_cmp++; if (busy_o !== 1'b0 || res_valid_o !== 1'b0) begin n_fail++; $display("FAIL clear_idle: got busy=%b valid=%b want 0 0", busy_o, res_valid_o); end
        n_cmp++; if (req_ready_o !== 1'b0) begin n_fail++; $display("FAIL clear_blocks_ready: got %b want 0", req_ready_o); end
        req_valid_i = 1'b1;
        data_i      = 32'd5;
        @(negedge clk_i);
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL clear_blocks_accept: got busy=%b want 0", busy_o); end
        clear_i     = 1'b0;
        req_valid_i = 1'b0;
        #1;
        n_cmp++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL clear_ready_back: got %b want 1", req_ready_o); end
        seen = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk_i);
            if (res_valid_o) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL clear_no_valid: got valid rose want never"); end
        run_op(32'h00AB_CDEF, 0, o);
        e = sb_q.pop_front();
        n_cmp++; if (o.int_v !== e.int_v || o.frac !== e.frac || o.err !== e.err) begin n_fail++; $display("FAIL clear_next_op: got %0d.%h want %0d.%h", o.int_v, o.frac, e.int_v, e.frac); end
    endtask

    task automatic test_rst_mid_frac();
        obs_t o;
        exp_t e;
        @(negedge clk_i);
        req_valid_i = 1'b1;
        data_i      = 32'h8000_0000;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        n_cmp++; if (busy_o !== 1'b1 || res_int_o !== 5'd31) begin n_fail++; $display("FAIL rst_pre_state: got busy=%b int=%0d want 1 31", busy_o, res_int_o); end
        #2 rst_i = 1'b1;
        #1;
        n_cmp++;
        if (req_ready_o !== 1'b1 || res_valid_o !== 1'b0 || res_int_o !== 5'd0 ||
            res_frac_o !== 8'h00 || err_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async: got rdy=%b vld=%b int=%0d frac=%h err=%b busy=%b want 1 0 0 00 0 0",
                     req_ready_o, res_valid_o, res_int_o, res_frac_o, err_o, busy_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        run_op(32'd3, 0, o);
        e = sb_q.pop_front();
        n_cmp++; if (o.int_v !== e.int_v || o.frac !== e.frac || o.lat != e.lat) begin n_fail++; $display("FAIL rst_next_op: got %0d.%h want %0d.%h", o.int_v, o.frac, e.int_v, e.frac); end
    endtask

    initial begin
        test_reset();
        test_msb_set();
        test_min_one();
        test_fraction();
        test_zero();
        test_backpressure();
        test_back_to_back();
        test_clear();
        test_rst_mid_frac();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
